// File: rtl/gpr_mp.sv
// gpr_mp: multi-port architectural register file with in-order commits, read bypass and a clear sweeper.
module gpr_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_CM   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CM-1:0]          commit_en,
  input  logic [NUM_CM*ADDR_W-1:0]   commit_addr,
  input  logic [NUM_CM*DATA_W-1:0]   commit_data,
  output logic                       commit_ready,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  assign commit_ready = state == IDLE;
  assign clr_busy     = state != IDLE;
  assign clr_done     = state == DONE;
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction
  // later commit ports overwrite earlier ones so the youngest value wins
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = in_range(a) ? regs[a] : '0;
    for (int k = 0; k < NUM_CM; k++)
      if (commit_ready && commit_en[k] && commit_addr[k*ADDR_W +: ADDR_W] == a)
        v = commit_data[k*DATA_W +: DATA_W];
    return (!in_range(a) || is_zero(a)) ? '0 : v;
  endfunction
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_data[p*DATA_W +: DATA_W] = rd_val(rd_addr[p*ADDR_W +: ADDR_W]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state == IDLE  ? (clr_req ? SWEEP : IDLE) :
               state == SWEEP ? (32'(idx) == NUM_REGS - 1 ? DONE : SWEEP) : IDLE;
      idx   <= state == SWEEP ? idx + 1'b1 : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == SWEEP) begin
      regs[idx] <= '0;
    end else if (commit_ready) begin
      for (int k = 0; k < NUM_CM; k++)
        if (commit_en[k] && in_range(commit_addr[k*ADDR_W +: ADDR_W]) && !is_zero(commit_addr[k*ADDR_W +: ADDR_W]))
          regs[commit_addr[k*ADDR_W +: ADDR_W]] <= commit_data[k*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: directed and random checks of gpr_mp against an array/counter reference model.
module tb_gpr_mp;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  commit_en = '0;
  logic [9:0]  commit_addr = '0;
  logic [63:0] commit_data = '0;
  logic        commit_ready;
  logic [14:0] rd_addr = '0;
  logic [95:0] rd_data;
  logic        clr_req = 0;
  logic        clr_busy;
  logic        clr_done;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] mregs [32];
  int sweep_pos = -1;
  gpr_mp dut (
    .clk(clk), .rst_n(rst_n), .commit_en(commit_en), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_ready(commit_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );
  always #5 clk = ~clk;
  function automatic logic m_ready();
    return sweep_pos == -1;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = mregs[a];
    if (m_ready())
      for (int k = 0; k < 2; k++)
        if (commit_en[k] && commit_addr[k*5 +: 5] == a) v = commit_data[k*32 +: 32];
    return a == 0 ? 32'h0 : v;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    sweep_pos = -1;
  endtask
  task automatic m_step();
    if (sweep_pos == -1) begin
      for (int k = 0; k < 2; k++)
        if (commit_en[k] && commit_addr[k*5 +: 5] != 0) mregs[commit_addr[k*5 +: 5]] = commit_data[k*32 +: 32];
      if (clr_req) sweep_pos = 0;
    end else if (sweep_pos < 32) begin
      mregs[sweep_pos] = '0;
      sweep_pos++;
    end else sweep_pos = -1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("commit_ready", {31'b0, commit_ready}, {31'b0, m_ready()});
    chk("clr_busy", {31'b0, clr_busy}, {31'b0, !m_ready()});
    chk("clr_done", {31'b0, clr_done}, {31'b0, sweep_pos == 32});
    for (int p = 0; p < 3; p++)
      chk($sformatf("rd%0d_x%0d", p, rd_addr[p*5 +: 5]), rd_data[p*32 +: 32], exp_rd(rd_addr[p*5 +: 5]));
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask
  task automatic cm(input int k, input logic en, input logic [4:0] a, input logic [31:0] d);
    commit_en[k] = en;
    commit_addr[k*5 +: 5] = a;
    commit_data[k*32 +: 32] = d;
  endtask
  task automatic rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask
  task automatic fill();
    for (int i = 1; i < 32; i += 2) begin
      cm(0, 1, 5'(i), 32'(i));
      cm(1, i + 1 < 32, 5'(i + 1), 32'(i + 1));
      #1 check_all();
      tick();
    end
    commit_en = '0;
  endtask
  initial begin
    int busy_cnt, done_cnt;
    m_reset();
    #2 check_all();
    #10 rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a)); rd(1, 5'(31 - a)); rd(2, 5'(a ^ 5));
      #1 check_all();
      chk("reset_zero", rd_data[31:0], 32'h0);
    end
    tick();
    cm(0, 1, 5, 32'hDEADBEEF); rd(1, 5);
    #1 chk("bypass_x5", rd_data[63:32], 32'hDEADBEEF);
    tick();
    commit_en = '0;
    #1 chk("stored_x5", rd_data[63:32], 32'hDEADBEEF);
    cm(0, 1, 7, 32'h11); cm(1, 1, 7, 32'h22); rd(2, 7);
    #1 chk("dup_bypass_x7", rd_data[95:64], 32'h22);
    tick();
    commit_en = '0;
    #1 chk("dup_stored_x7", rd_data[95:64], 32'h22);
    cm(0, 1, 0, 32'hFFFFFFFF); rd(0, 0);
    #1 chk("x0_same", rd_data[31:0], 32'h0);
    tick();
    commit_en = '0;
    #1 chk("x0_after", rd_data[31:0], 32'h0);
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 2; k++) cm(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom);
      for (int p = 0; p < 3; p++) rd(p, 5'($urandom_range(0, 31)));
      clr_req = $urandom_range(0, 60) == 0;
      #1 check_all();
      tick();
    end
    clr_req = 0; commit_en = '0;
    while (!m_ready()) tick();
    fill();
    clr_req = 1;
    #1 check_all();
    tick();
    clr_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      rd(0, 3); rd(1, 31); rd(2, 9);
      if (c == 6) cm(0, 1, 9, 32'h55);
      #1 check_all();
      if (c == 5) begin
        chk("swept_x3", rd_data[31:0], 32'h0);
        chk("unswept_x31", rd_data[63:32], 32'd31);
      end
      busy_cnt += clr_busy;
      done_cnt += clr_done;
      tick();
      commit_en = '0;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd33);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("x9_dropped", rd_data[95:64], 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a));
      #1 chk("cleared", rd_data[31:0], 32'h0);
    end
    fill();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int c = 0; c < 10; c++) begin
      rd(0, 5'(c)); rd(1, 20); rd(2, 5'(c + 1));
      #1 check_all();
      tick();
    end
    rst_n = 0;
    m_reset();
    rd(1, 20);
    #1 check_all();
    chk("abort_x20", rd_data[63:32], 32'h0);
    rst_n = 1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      rd(0, 5'(c)); rd(2, 5'(31 - c));
      #1 check_all();
      done_cnt += clr_done;
      tick();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
